// File: rtl/mem_access_sched.sv
// Shared single-port memory sequencer for the instruction-fetch and load/store paths.
// Round-robin arbitration between the two requesters, read wait-state counting,
// read-modify-write for byte/halfword stores, zero-extended load lanes and
// misalignment reporting. Every output is a registered value.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   if_req/if_addr               fetch request (held until if_done)
//   if_rdata/if_done             fetched word and one-cycle completion pulse
//   d_req/d_we/d_size/d_addr/d_wdata  data request (held until d_done)
//   d_rdata/d_done/d_err         load data, completion pulse, misaligned flag
//   mem_addr/mem_wr/mem_wdata    memory address, write enable, write data
//   mem_rdata                    memory read data
//   busy                         high whenever the sequencer is not idle
module mem_access_sched #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_RMW_RD, S_RMW_WR, S_WR, S_DONE
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               last_fetch_q, last_fetch_n;
  logic               cur_fetch_q, cur_fetch_n;
  logic [1:0]         size_q, size_n;
  logic [1:0]         lane_q, lane_n;
  logic [31:0]        wdata_q, wdata_n;
  logic [31:0]        if_rdata_n, d_rdata_n, mem_addr_n, mem_wdata_n;
  logic               if_done_n, d_done_n, d_err_n, mem_wr_n, busy_n;
  logic               grant_fetch, d_mis, f_mis;

  // Right-aligned, zero-extended load lane; size 11 is a word.
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane);
    logic [31:0] sh;
    sh = 32'd0;
    case (size)
      2'b10: begin
        sh = w >> {lane, 3'b000};
        return {24'd0, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {lane[1], 4'b0000};
        return {16'd0, sh[15:0]};
      end
      default: return w;
    endcase
  endfunction

  // Replace only the addressed byte/halfword lane of the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask, data;
    if (size == 2'b10) begin
      mask = 32'h0000_00ff << {lane, 3'b000};
      data = {24'd0, wd[7:0]} << {lane, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {lane[1], 4'b0000};
      data = {16'd0, wd[15:0]} << {lane[1], 4'b0000};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  // Tie goes to the requester not served last.
  assign grant_fetch = if_req && (!d_req || !last_fetch_q);
  assign f_mis       = (if_addr[1:0] != 2'b00);
  assign d_mis       = ((d_size == 2'b01) && d_addr[0]) ||
                       ((d_size == 2'b00 || d_size == 2'b11) && (d_addr[1:0] != 2'b00));

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_fetch_q <= 1'b0;
      cur_fetch_q  <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      if_rdata     <= '0;
      if_done      <= 1'b0;
      d_rdata      <= '0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
      mem_addr     <= '0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      last_fetch_q <= last_fetch_n;
      cur_fetch_q  <= cur_fetch_n;
      size_q       <= size_n;
      lane_q       <= lane_n;
      wdata_q      <= wdata_n;
      if_rdata     <= if_rdata_n;
      if_done      <= if_done_n;
      d_rdata      <= d_rdata_n;
      d_done       <= d_done_n;
      d_err        <= d_err_n;
      mem_addr     <= mem_addr_n;
      mem_wr       <= mem_wr_n;
      mem_wdata    <= mem_wdata_n;
      busy         <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    last_fetch_n = last_fetch_q;
    cur_fetch_n  = cur_fetch_q;
    size_n       = size_q;
    lane_n       = lane_q;
    wdata_n      = wdata_q;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wr_n     = 1'b0;
    if_rdata_n   = '0;
    if_done_n    = 1'b0;
    d_rdata_n    = '0;
    d_done_n     = 1'b0;
    d_err_n      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          cur_fetch_n = grant_fetch;
          cnt_n       = CNT_W'(RD_LAT);
          size_n      = d_size;
          lane_n      = d_addr[1:0];
          wdata_n     = d_wdata;
          if (grant_fetch) begin
            mem_addr_n = {if_addr[31:2], 2'b00};
            if (f_mis) begin
              state_n   = S_DONE;
              if_done_n = 1'b1;
            end else begin
              state_n   = S_RD_WAIT;
            end
          end else begin
            mem_addr_n = {d_addr[31:2], 2'b00};
            if (d_mis) begin
              state_n  = S_DONE;
              d_done_n = 1'b1;
              d_err_n  = 1'b1;
            end else if (!d_we) begin
              state_n  = S_RD_WAIT;
            end else if (d_size == 2'b01 || d_size == 2'b10) begin
              state_n  = S_RMW_RD;
            end else begin
              state_n     = S_WR;
              mem_wr_n    = 1'b1;
              mem_wdata_n = d_wdata;
            end
          end
        end
      end
      S_RD_WAIT: begin
        // A count of 1 marks the edge at which the read data is valid.
        if (cnt_q == CNT_W'(1)) begin
          state_n = S_DONE;
          if (cur_fetch_q) begin
            if_done_n  = 1'b1;
            if_rdata_n = mem_rdata;
          end else begin
            d_done_n  = 1'b1;
            d_rdata_n = lane_extract(mem_rdata, size_q, lane_q);
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_RMW_RD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_n     = S_RMW_WR;
          mem_wr_n    = 1'b1;
          mem_wdata_n = lane_merge(mem_rdata, wdata_q, size_q, lane_q);
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_RMW_WR, S_WR: begin
        state_n  = S_DONE;
        d_done_n = 1'b1;
      end
      S_DONE: begin
        state_n      = S_IDLE;
        last_fetch_n = cur_fetch_q;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_mem_access_sched.sv
// Directed bench for mem_access_sched with a small word memory model (RD_LAT=2).
module tb_mem_access_sched;

  localparam int unsigned RD_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;
  int n_wr    = 0;
  int n_dd    = 0;
  int n_both  = 0;

  logic [31:0] mem [0:15];
  logic        mem_load;

  always #5 clock = ~clock;

  mem_access_sched #(.RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Combinational-read word memory; writes land at the clock edge.
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8C22_0004;
      mem[8] <= 32'h1122_3344;
    end else if (mem_wr) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  always @(negedge clock) begin
    if (mem_wr) n_wr++;
    if (d_done) n_dd++;
    if (if_done && d_done) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "/idle"}, 32'(busy), 32'd0);
  endtask

  task automatic reload_mem();
    mem_load = 1'b1;
    @(negedge clock);
    mem_load = 1'b0;
  endtask

  task automatic data_txn(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_k, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_nwr, input logic [31:0] exp_wdata);
    int k, nwr;
    logic [31:0] wd, wa, rd;
    logic got, err;
    wait_idle(tag);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    k = 0; nwr = 0; wd = '0; wa = '0; rd = '0; got = 1'b0; err = 1'b0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (mem_wr) begin nwr++; wd = mem_wdata; wa = mem_addr; end
      if (if_done) check({tag, "/stray_if_done"}, 32'(if_done), 32'd0);
      if (d_done) begin got = 1'b1; rd = d_rdata; err = d_err; end
    end
    d_req = 1'b0;
    check({tag, "/latency"}, 32'(k), 32'(exp_k));
    check({tag, "/rdata"}, rd, exp_rdata);
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/nwr"}, 32'(nwr), 32'(exp_nwr));
    check({tag, "/mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    if (exp_nwr > 0) begin
      check({tag, "/wdata"}, wd, exp_wdata);
      check({tag, "/waddr"}, wa, {addr[31:2], 2'b00});
    end
    @(negedge clock);
    check({tag, "/pulse"}, 32'(d_done), 32'd0);
  endtask

  task automatic fetch_txn(input string tag, input logic [31:0] addr, input int exp_k,
                           input logic [31:0] exp_rdata);
    int k, nwr;
    logic [31:0] rd;
    logic got;
    wait_idle(tag);
    if_req = 1'b1; if_addr = addr;
    k = 0; nwr = 0; rd = '0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (mem_wr) nwr++;
      if (d_done) check({tag, "/stray_d_done"}, 32'(d_done), 32'd0);
      if (if_done) begin got = 1'b1; rd = if_rdata; end
    end
    if_req = 1'b0;
    check({tag, "/latency"}, 32'(k), 32'(exp_k));
    check({tag, "/rdata"}, rd, exp_rdata);
    check({tag, "/nwr"}, 32'(nwr), 32'd0);
    @(negedge clock);
    check({tag, "/pulse"}, 32'(if_done), 32'd0);
  endtask

  // Fetch 0x10 against lw 0x20 issued in the same cycle.
  task automatic tie_txn(input string tag, input logic exp_fetch_first);
    int k, nif, nd;
    logic first_fetch, seen_first;
    wait_idle(tag);
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h20; d_wdata = '0;
    k = 0; nif = 0; nd = 0; first_fetch = 1'b0; seen_first = 1'b0;
    while ((nif == 0 || nd == 0) && k < 80) begin
      @(negedge clock);
      k++;
      if (if_done) begin
        nif++;
        if_req = 1'b0;
        check({tag, "/if_rdata"}, if_rdata, 32'h8C22_0004);
        if (!seen_first) begin seen_first = 1'b1; first_fetch = 1'b1; end
      end
      if (d_done) begin
        nd++;
        d_req = 1'b0;
        check({tag, "/d_rdata"}, d_rdata, 32'h1122_3344);
        if (!seen_first) begin seen_first = 1'b1; first_fetch = 1'b0; end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (if_done) nif++;
      if (d_done) nd++;
    end
    check({tag, "/fetch_first"}, 32'(first_fetch), 32'(exp_fetch_first));
    check({tag, "/n_if_done"}, 32'(nif), 32'd1);
    check({tag, "/n_d_done"}, 32'(nd), 32'd1);
  endtask

  initial begin
    int wr0, dd0;
    reset = 1'b1; mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0; mem_load = 1'b0;

    check("reset/ctrl", {27'd0, mem_wr, if_done, d_done, d_err, busy}, 32'd0);
    check("reset/data", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);

    // Tie right after reset: fetch first.
    tie_txn("tie1", 1'b1);
    fetch_txn("fetch10", 32'h10, RD_LAT + 1, 32'h8C22_0004);
    // Last grant was fetch, so data wins this tie.
    tie_txn("tie2", 1'b0);
    fetch_txn("fetch_mis", 32'h12, 1, 32'd0);

    reload_mem();
    data_txn("lb22", 1'b0, 2'b10, 32'h22, '0, RD_LAT + 1, 32'h0000_0022, 1'b0, 0, '0);
    data_txn("lh22", 1'b0, 2'b01, 32'h22, '0, RD_LAT + 1, 32'h0000_1122, 1'b0, 0, '0);
    data_txn("lb20", 1'b0, 2'b10, 32'h20, '0, RD_LAT + 1, 32'h0000_0044, 1'b0, 0, '0);
    data_txn("lb21", 1'b0, 2'b10, 32'h21, '0, RD_LAT + 1, 32'h0000_0033, 1'b0, 0, '0);
    data_txn("lh20", 1'b0, 2'b01, 32'h20, '0, RD_LAT + 1, 32'h0000_3344, 1'b0, 0, '0);
    data_txn("lw_sz3", 1'b0, 2'b11, 32'h20, '0, RD_LAT + 1, 32'h1122_3344, 1'b0, 0, '0);
    data_txn("sb23", 1'b1, 2'b10, 32'h23, 32'h0000_00AB, RD_LAT + 2, 32'd0, 1'b0, 1,
             32'hAB22_3344);
    data_txn("lw20a", 1'b0, 2'b00, 32'h20, '0, RD_LAT + 1, 32'hAB22_3344, 1'b0, 0, '0);
    data_txn("sh22", 1'b1, 2'b01, 32'h22, 32'hFFFF_5566, RD_LAT + 2, 32'd0, 1'b0, 1,
             32'h5566_3344);
    data_txn("sb20", 1'b1, 2'b10, 32'h20, 32'h1234_5699, RD_LAT + 2, 32'd0, 1'b0, 1,
             32'h5566_3399);
    data_txn("sw20", 1'b1, 2'b00, 32'h20, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1, 32'hDEAD_BEEF);
    data_txn("lw20b", 1'b0, 2'b00, 32'h20, '0, RD_LAT + 1, 32'hDEAD_BEEF, 1'b0, 0, '0);
    data_txn("sh21_mis", 1'b1, 2'b01, 32'h21, 32'h0000_1234, 1, 32'd0, 1'b1, 0, '0);
    data_txn("lw22_mis", 1'b0, 2'b00, 32'h22, '0, 1, 32'd0, 1'b1, 0, '0);
    data_txn("lh23_mis", 1'b0, 2'b01, 32'h23, '0, 1, 32'd0, 1'b1, 0, '0);

    // Reset in the middle of a byte RMW: nothing written, no completion.
    reload_mem();
    wait_idle("rst_mid");
    #1;
    wr0 = n_wr; dd0 = n_dd;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h20; d_wdata = 32'h0000_0055;
    @(negedge clock);
    check("rst_mid/busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid/ctrl", {27'd0, mem_wr, if_done, d_done, d_err, busy}, 32'd0);
    check("rst_mid/data", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    check("rst_mid/no_wr", 32'(n_wr - wr0), 32'd0);
    check("rst_mid/no_done", 32'(n_dd - dd0), 32'd0);
    @(negedge clock);
    data_txn("lw_after_rst", 1'b0, 2'b00, 32'h20, '0, RD_LAT + 1, 32'h1122_3344, 1'b0, 0, '0);

    #1;
    check("never_both_done", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
